riscv_stall_ctrl: RTL and testbench
===================================

# riscv_stall_ctrl

Pipeline control unit for the five-stage (F/D/X/M/W) stall-only RISC-V core with no bypass network. It consumes the one-hot instruction-class flags produced by the decoder, tracks in-flight destination registers in X/M/W, and generates per-stage stall, squash and valid signals. It also sequences the instruction and data memory handshakes and keeps a stall-cycle performance counter.

## Interface
- `CNT_W`, 32, width of the stall-cycle counter
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `inst_val_D`  in  1  valid instruction in D
- `rs1_en_D`, `rs2_en_D`  in  1  source register is read
- `rs1_D`, `rs2_D`, `rd_D`  in  5  register addresses
- `rd_en_D`  in  1  instruction writes rd
- `is_load_D`, `is_store_D`  in  1  OR of the load / store decoder flags
- `brj_taken_X`  in  1  branch/jump in X resolved taken
- `imem_resp_val`  in  1  fetch data valid
- `dmem_req_rdy`  in  1  data memory accepts a request
- `dmem_resp_val`  in  1  data memory response valid
- `stall_F`, `stall_D`, `stall_X`, `stall_M`  out  1  hold stage register
- `squash_D`  out  1  kill D instruction, redirect PC
- `val_X`, `val_M`, `val_W`  out  1  stage holds a live instruction
- `dmem_req_val`  out  1  issue memory request from X
- `rf_wen_W`, `rf_waddr_W`  out  1, 5  register-file write
- `stall_cnt`  out  CNT_W  cycles with `stall_D` high

## Operation
- Per-stage state (X, M, W): valid, rd_en, rd[4:0], is_mem, is_load.
- RAW hazard: `raw_D` = `inst_val_D` and, for any enabled source s with s≠0, s equals rd of a valid, rd_en entry in X, M or W.
- `stall_M` = `val_M` & is_mem_M & !`dmem_resp_val`.
- `stall_X` = `stall_M` | (`val_X` & is_mem_X & !`dmem_req_rdy`).
- `stall_D` = `stall_X` | (`raw_D` & !`squash_D`).
- `stall_F` = `stall_D` | !`imem_resp_val`.
- `squash_D` = `brj_taken_X` & `val_X` & !`stall_X`; overrides RAW. The squashed D instruction never enters X.
- `dmem_req_val` = `val_X` & is_mem_X & !`stall_M`.
- Advance: X←D when !`stall_X`; the new valid is `inst_val_D` & !`stall_D` & !`squash_D`, otherwise a bubble. M←X when !`stall_M`; the entry is a bubble if `stall_X`. W←M every cycle; the entry is a bubble if `stall_M`.
- `rf_wen_W` = `val_W` & rd_en_W & (rd_W≠0).
- `stall_cnt` increments when `stall_D`=1, wraps at 2^CNT_W, never saturates.

## Timing
- Reset (async assert, sync-safe deassert): all valid bits 0, `stall_cnt`=0, `rf_wen_W`=0, `dmem_req_val`=0, `squash_D`=0, `stall_D`/`stall_X`/`stall_M`=0. `stall_F` follows `imem_resp_val`.
- Stall/squash outputs are combinational from state and inputs within the same cycle. State updates on the rising edge.
- Hazard window: a dependent instruction stalls in D for 3 cycles behind its producer in X, 2 behind M, 1 behind W. It issues in the cycle after the producer leaves W.
- Load in M waits indefinitely for `dmem_resp_val`. During the wait X, D and F hold and W receives bubbles.
- Reset asserted mid-stall: the pipeline empties immediately and `stall_cnt` clears. No request is held across reset.

## Structure
- Shared package `riscv_ctrl_pkg`: `REG_ADDR_W`=5, the stage-entry struct typedef (valid, rd_en, rd, is_mem, is_load), and the `X0` constant.
- One sub-module, `riscv_hazard_cmp`: compares one source register against the three stage entries and returns a hit. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x3` back-to-back -> `stall_D` high exactly 3 cycles, then the sub enters X. `stall_cnt`=3.
- Producer writes x0, consumer reads x0 -> no stall. `rf_wen_W`=0 for the producer.
- `lw x7` with `dmem_resp_val` delayed 4 cycles -> `stall_M`/`stall_X`/`stall_D` high for 4 cycles, `val_W`=0 during the wait, then `rf_wen_W`=1 with `rf_waddr_W`=7.
- `brj_taken_X`=1 while D holds an instruction with a RAW hit -> `squash_D`=1, `stall_D`=0, and next cycle `val_X`=0.
- Store in X with `dmem_req_rdy`=0 for 2 cycles -> `dmem_req_val`=1 throughout, `stall_X`=1 for 2 cycles, and the instruction advances to M on the third cycle.
- Assert `reset_n`=0 during the load wait -> all valids and `stall_cnt` go to 0 immediately. After release, the first instruction flows with no stall.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the stall-only pipeline control: stage-entry layout and register constants.
package riscv_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic                  valid;
        logic                  rd_en;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_mem;
        logic                  is_load;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // True when a live stage entry will write register r.
    function automatic logic writes_reg(stage_t e, logic [REG_ADDR_W-1:0] r);
        return e.valid & e.rd_en & (e.rd == r);
    endfunction

endpackage

// File: rtl/riscv_hazard_cmp.sv
// One source operand against the in-flight destinations of X, M and W.
module riscv_hazard_cmp
    import riscv_ctrl_pkg::*;
(
    input  logic                  src_en,
    input  logic [REG_ADDR_W-1:0] src,
    input  stage_t                ent_x,
    input  stage_t                ent_m,
    input  stage_t                ent_w,
    output logic                  hit
);

    // x0 is hardwired, so reading it can never depend on a producer.
    assign hit = src_en & (src != X0) &
                 (writes_reg(ent_x, src) | writes_reg(ent_m, src) | writes_reg(ent_w, src));

    logic unused_flags;
    assign unused_flags = ^{ent_x.is_mem, ent_x.is_load, ent_m.is_mem, ent_m.is_load,
                            ent_w.is_mem, ent_w.is_load};

endmodule

// File: rtl/riscv_stall_ctrl.sv
// Stall/squash/valid control for the five-stage stall-only core, with memory handshakes
// and a stall-cycle counter.
module riscv_stall_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inst_val_D,
    input  logic                  rs1_en_D,
    input  logic                  rs2_en_D,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rd_D,
    input  logic                  rd_en_D,
    input  logic                  is_load_D,
    input  logic                  is_store_D,
    input  logic                  brj_taken_X,
    input  logic                  imem_resp_val,
    input  logic                  dmem_req_rdy,
    input  logic                  dmem_resp_val,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  stall_X,
    output logic                  stall_M,
    output logic                  squash_D,
    output logic                  val_X,
    output logic                  val_M,
    output logic                  val_W,
    output logic                  dmem_req_val,
    output logic                  rf_wen_W,
    output logic [REG_ADDR_W-1:0] rf_waddr_W,
    output logic [CNT_W-1:0]      stall_cnt
);

    stage_t x_q, m_q, w_q;
    stage_t x_d;
    logic   hit_rs1, hit_rs2, raw_D;

    riscv_hazard_cmp u_cmp_rs1 (
        .src_en (rs1_en_D),
        .src    (rs1_D),
        .ent_x  (x_q),
        .ent_m  (m_q),
        .ent_w  (w_q),
        .hit    (hit_rs1)
    );

    riscv_hazard_cmp u_cmp_rs2 (
        .src_en (rs2_en_D),
        .src    (rs2_D),
        .ent_x  (x_q),
        .ent_m  (m_q),
        .ent_w  (w_q),
        .hit    (hit_rs2)
    );

    assign raw_D = inst_val_D & (hit_rs1 | hit_rs2);

    // Stalls propagate backwards from M; a taken branch in X outranks a RAW stall in D.
    assign stall_M  = m_q.valid & m_q.is_mem & ~dmem_resp_val;
    assign stall_X  = stall_M | (x_q.valid & x_q.is_mem & ~dmem_req_rdy);
    assign squash_D = brj_taken_X & x_q.valid & ~stall_X;
    assign stall_D  = stall_X | (raw_D & ~squash_D);
    assign stall_F  = stall_D | ~imem_resp_val;

    assign dmem_req_val = x_q.valid & x_q.is_mem & ~stall_M;

    always_comb begin
        x_d         = BUBBLE;
        x_d.valid   = inst_val_D & ~stall_D & ~squash_D;
        x_d.rd_en   = rd_en_D;
        x_d.rd      = rd_D;
        x_d.is_mem  = is_load_D | is_store_D;
        x_d.is_load = is_load_D;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= BUBBLE;
            m_q       <= BUBBLE;
            w_q       <= BUBBLE;
            stall_cnt <= '0;
        end else begin
            if (!stall_X)
                x_q <= x_d;
            if (!stall_M)
                m_q <= stall_X ? BUBBLE : x_q;
            w_q <= stall_M ? BUBBLE : m_q;
            if (stall_D)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign val_X      = x_q.valid;
    assign val_M      = m_q.valid;
    assign val_W      = w_q.valid;
    assign rf_wen_W   = w_q.valid & w_q.rd_en & (w_q.rd != X0);
    assign rf_waddr_W = w_q.rd;

    logic unused_stage;
    assign unused_stage = ^{x_q.is_load, m_q.is_load, w_q.is_mem, w_q.is_load};

endmodule

// File: tb/tb_riscv_stall_ctrl.sv
// Directed bench for riscv_stall_ctrl: hazard window, x0, load wait, squash, store backpressure, reset.
module tb_riscv_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_val_D, rs1_en_D, rs2_en_D, rd_en_D, is_load_D, is_store_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        brj_taken_X, imem_resp_val, dmem_req_rdy, dmem_resp_val;
    logic        stall_F, stall_D, stall_X, stall_M, squash_D;
    logic        val_X, val_M, val_W, dmem_req_val, rf_wen_W;
    logic [4:0]  rf_waddr_W;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_stall_ctrl #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .inst_val_D    (inst_val_D),
        .rs1_en_D      (rs1_en_D),
        .rs2_en_D      (rs2_en_D),
        .rs1_D         (rs1_D),
        .rs2_D         (rs2_D),
        .rd_D          (rd_D),
        .rd_en_D       (rd_en_D),
        .is_load_D     (is_load_D),
        .is_store_D    (is_store_D),
        .brj_taken_X   (brj_taken_X),
        .imem_resp_val (imem_resp_val),
        .dmem_req_rdy  (dmem_req_rdy),
        .dmem_resp_val (dmem_resp_val),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .stall_X       (stall_X),
        .stall_M       (stall_M),
        .squash_D      (squash_D),
        .val_X         (val_X),
        .val_M         (val_M),
        .val_W         (val_W),
        .dmem_req_val  (dmem_req_val),
        .rf_wen_W      (rf_wen_W),
        .rf_waddr_W    (rf_waddr_W),
        .stall_cnt     (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction in D (val=0 gives an empty slot).
    task automatic drive_d(input logic v, input logic e1, input logic [4:0] r1,
                           input logic e2, input logic [4:0] r2,
                           input logic we, input logic [4:0] rd,
                           input logic ld, input logic st);
        inst_val_D = v;  rs1_en_D = e1; rs1_D = r1; rs2_en_D = e2; rs2_D = r2;
        rd_en_D = we;    rd_D = rd;     is_load_D = ld; is_store_D = st;
    endtask

    task automatic idle_d();
        drive_d(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock; inputs change and checks happen mid-cycle, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        brj_taken_X = 1'b0; imem_resp_val = 1'b0; dmem_req_rdy = 1'b1; dmem_resp_val = 1'b1;
        idle_d();
        #2;
        chk("rst_val_X", val_X, 0);
        chk("rst_val_M", val_M, 0);
        chk("rst_val_W", val_W, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_wen", rf_wen_W, 0);
        chk("rst_dreq", dmem_req_val, 0);
        chk("rst_squash", squash_D, 0);
        chk("rst_stall_D", stall_D, 0);
        chk("rst_stall_F_imem0", stall_F, 1);
        imem_resp_val = 1'b1;
        #1;
        chk("rst_stall_F_imem1", stall_F, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // add x5,x1,x2 ; sub x6,x5,x3
        drive_d(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 0);
        #1 chk("raw_add_nostall", stall_D, 0);
        tick();
        drive_d(1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 0, 0);
        #1 chk("raw_c1_stall", stall_D, 1);
        chk("raw_c1_valX", val_X, 1);
        chk("raw_c1_stallF", stall_F, 1);
        tick();
        #1 chk("raw_c2_stall", stall_D, 1);
        chk("raw_c2_valX_bubble", val_X, 0);
        chk("raw_c2_valM", val_M, 1);
        tick();
        #1 chk("raw_c3_stall", stall_D, 1);
        chk("raw_c3_wen", rf_wen_W, 1);
        chk("raw_c3_waddr", rf_waddr_W, 5);
        tick();
        #1 chk("raw_c4_issue", stall_D, 0);
        chk("raw_c4_cnt", stall_cnt, 3);
        tick();
        idle_d();
        #1 chk("raw_sub_in_X", val_X, 1);
        chk("raw_cnt_hold", stall_cnt, 3);
        repeat (3) tick();

        // x0 producer then x0 consumer
        drive_d(1, 1, 5'd1, 0, 5'd0, 1, 5'd0, 0, 0);
        tick();
        drive_d(1, 1, 5'd0, 1, 5'd0, 1, 5'd8, 0, 0);
        #1 chk("x0_nostall", stall_D, 0);
        tick();
        idle_d();
        tick();
        #1 chk("x0_prod_valW", val_W, 1);
        chk("x0_prod_nowen", rf_wen_W, 0);
        tick();
        #1 chk("x0_cons_wen", rf_wen_W, 1);
        chk("x0_cons_waddr", rf_waddr_W, 8);
        chk("x0_cnt", stall_cnt, 3);
        repeat (2) tick();

        // lw x7 with response delayed 4 cycles, independent add x9 behind it
        dmem_resp_val = 1'b0;
        drive_d(1, 1, 5'd1, 0, 5'd0, 1, 5'd7, 1, 0);
        tick();
        drive_d(1, 1, 5'd1, 1, 5'd2, 1, 5'd9, 0, 0);
        #1 chk("ld_X_req", dmem_req_val, 1);
        chk("ld_X_nostallX", stall_X, 0);
        tick();
        idle_d();
        for (int i = 0; i < 4; i++) begin
            #1 chk("ld_wait_stallM", stall_M, 1);
            chk("ld_wait_stallX", stall_X, 1);
            chk("ld_wait_stallD", stall_D, 1);
            chk("ld_wait_valW", val_W, 0);
            chk("ld_wait_valX", val_X, 1);
            chk("ld_wait_dreq", dmem_req_val, 0);
            tick();
        end
        dmem_resp_val = 1'b1;
        #1 chk("ld_resp_stallM", stall_M, 0);
        chk("ld_resp_stallD", stall_D, 0);
        chk("ld_cnt", stall_cnt, 7);
        tick();
        #1 chk("ld_wen", rf_wen_W, 1);
        chk("ld_waddr", rf_waddr_W, 7);
        repeat (3) tick();

        // taken branch in X while D has a RAW hit on a producer in M
        drive_d(1, 1, 5'd1, 0, 5'd0, 1, 5'd10, 0, 0);
        tick();
        drive_d(1, 1, 5'd1, 1, 5'd2, 0, 5'd0, 0, 0);
        tick();
        drive_d(1, 1, 5'd10, 0, 5'd0, 1, 5'd11, 0, 0);
        #1 chk("br_raw_before", stall_D, 1);
        brj_taken_X = 1'b1;
        #1 chk("br_squash", squash_D, 1);
        chk("br_nostallD", stall_D, 0);
        tick();
        brj_taken_X = 1'b0;
        idle_d();
        #1 chk("br_valX_killed", val_X, 0);
        chk("br_cnt", stall_cnt, 7);
        repeat (3) tick();

        // store in X with 2 cycles of request backpressure
        dmem_req_rdy = 1'b0;
        drive_d(1, 1, 5'd1, 1, 5'd2, 0, 5'd0, 0, 1);
        tick();
        idle_d();
        for (int i = 0; i < 2; i++) begin
            #1 chk("st_bp_dreq", dmem_req_val, 1);
            chk("st_bp_stallX", stall_X, 1);
            chk("st_bp_valM", val_M, 0);
            tick();
        end
        dmem_req_rdy = 1'b1;
        #1 chk("st_go_dreq", dmem_req_val, 1);
        chk("st_go_stallX", stall_X, 0);
        chk("st_cnt", stall_cnt, 9);
        tick();
        #1 chk("st_in_M", val_M, 1);
        chk("st_left_X", val_X, 0);
        repeat (3) tick();

        // reset during a load wait
        dmem_resp_val = 1'b0;
        drive_d(1, 1, 5'd1, 0, 5'd0, 1, 5'd7, 1, 0);
        tick();
        drive_d(1, 1, 5'd2, 0, 5'd0, 1, 5'd11, 0, 0);
        tick();
        idle_d();
        #1 chk("rl_stallD", stall_D, 1);
        repeat (2) tick();
        #1 chk("rl_cnt_pre", stall_cnt, 11);
        reset_n = 1'b0;
        #1 chk("rl_valX", val_X, 0);
        chk("rl_valM", val_M, 0);
        chk("rl_valW", val_W, 0);
        chk("rl_cnt", stall_cnt, 0);
        chk("rl_stallM", stall_M, 0);
        tick();
        reset_n = 1'b1;
        dmem_resp_val = 1'b1;
        drive_d(1, 1, 5'd7, 0, 5'd0, 1, 5'd12, 0, 0);
        #1 chk("rl_after_nostall", stall_D, 0);
        tick();
        idle_d();
        #1 chk("rl_after_valX", val_X, 1);
        chk("rl_after_cnt", stall_cnt, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
